dm_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data memory (DM) of the MIPS datapath.
- Port 0 is the pipeline MEM stage. Port 1 is a secondary master (debug/bridge loader).
- Grants one word access at a time and converts byte addresses to DM word indices.
- Rejects misaligned and out-of-range accesses with an error response. Port 1 is protected from starvation by a bounded-wait counter.

---
 rtl/dm_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// One word access per grant; misaligned or out-of-range addresses get an error response.

module dm_arb_port (
    input  logic        gclk,
    input  logic        grst_n,
    input  logic        sel,
    input  logic        resp,
    input  logic        rd_cap,
    input  logic        err_flag,
    input  logic [31:0] d,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata
);
    assign ack = resp && sel;
    assign err = ack && err_flag;

    // Read data is sticky: only a successful read by this port replaces it.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            rdata <= '0;
        else if (rd_cap && sel)
            rdata <= d;
    end
endmodule

module dm_arbiter #(
    parameter int DEPTH      = 4096,
    parameter int STARVE_LIM = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0_In,
    input  logic        We0_In,
    input  logic [31:0] Addr0_In,
    input  logic [31:0] WData0_In,
    input  logic [31:0] Pc0_In,
    output logic        Ack0_Out,
    output logic        Err0_Out,
    output logic [31:0] RData0_Out,
    input  logic        Req1_In,
    input  logic        We1_In,
    input  logic [31:0] Addr1_In,
    input  logic [31:0] WData1_In,
    input  logic [31:0] Pc1_In,
    output logic        Ack1_Out,
    output logic        Err1_Out,
    output logic [31:0] RData1_Out,
    output logic        Mem_Write_Out,
    output logic [31:0] Mem_Addr_Out,
    output logic [31:0] Mem_Data_Out,
    output logic [31:0] Mem_Pc_Out,
    input  logic [31:0] Mem_Data_In,
    output logic        Busy_Out
);
    localparam int NUM_PORTS = 2;
    localparam int WW        = $clog2(STARVE_LIM + 1);
    localparam logic [WW-1:0] LIM = WW'(STARVE_LIM);

    typedef enum logic [1:0] {ARB, ACCESS, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [29:0] idx;
        logic [31:0] wdata;
        logic [31:0] pc;
    } acc_t;

    state_t  state, state_nx;
    acc_t    cur, cur_nx;
    logic    win, win_nx;
    logic    err, err_nx;
    logic    grant1;
    logic    in_access, rd_cap;
    logic [WW-1:0] wait1, wait1_nx;

    logic [NUM_PORTS-1:0]        req, ack, errs;
    logic [NUM_PORTS-1:0][31:0]  addr, rdata;
    acc_t [NUM_PORTS-1:0]        port_acc;

    assign req  = {Req1_In, Req0_In};
    assign addr = {Addr1_In, Addr0_In};
    assign port_acc[0] = '{we: We0_In, idx: Addr0_In[31:2], wdata: WData0_In, pc: Pc0_In};
    assign port_acc[1] = '{we: We1_In, idx: Addr1_In[31:2], wdata: WData1_In, pc: Pc1_In};

    // Port 1 takes the slot when alone, or when it has lost STARVE_LIM conflicts in a row.
    assign grant1 = req[1] && (!req[0] || wait1 == LIM);

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        win_nx   = win;
        err_nx   = err;
        wait1_nx = wait1;
        case (state)
            ARB: begin
                if (|req) begin
                    win_nx = grant1;
                    cur_nx = port_acc[grant1];
                    err_nx = (addr[grant1][1:0] != 2'b00) ||
                             ({2'b00, addr[grant1][31:2]} >= 32'(DEPTH));
                    state_nx = err_nx ? RESP : ACCESS;
                    if (grant1)
                        wait1_nx = '0;
                    else if (req[1] && wait1 != LIM)
                        wait1_nx = wait1 + WW'(1);
                end
            end
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = ARB;
            default: state_nx = ARB;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ARB;
            cur   <= '0;
            win   <= 1'b0;
            err   <= 1'b0;
            wait1 <= '0;
        end else begin
            state <= state_nx;
            cur   <= cur_nx;
            win   <= win_nx;
            err   <= err_nx;
            wait1 <= wait1_nx;
        end
    end

    // DM strobes decode straight from registered state so reset kills them at once.
    assign in_access     = (state == ACCESS);
    assign rd_cap        = in_access && !cur.we;
    assign Mem_Write_Out = in_access && cur.we;
    assign Mem_Addr_Out  = in_access ? {2'b00, cur.idx} : '0;
    assign Mem_Data_Out  = in_access ? cur.wdata : '0;
    assign Mem_Pc_Out    = in_access ? cur.pc : '0;
    assign Busy_Out      = (state != ARB);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        dm_arb_port u_port (
            .gclk     (Clk),
            .grst_n   (Reset),
            .sel      (win == 1'(p)),
            .resp     (state == RESP),
            .rd_cap   (rd_cap),
            .err_flag (err),
            .d        (Mem_Data_In),
            .ack      (ack[p]),
            .err      (errs[p]),
            .rdata    (rdata[p])
        );
    end

    assign Ack0_Out   = ack[0];
    assign Err0_Out   = errs[0];
    assign RData0_Out = rdata[0];
    assign Ack1_Out   = ack[1];
    assign Err1_Out   = errs[1];
    assign RData1_Out = rdata[1];
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: transaction-level model (grant slots, shadow memory) checked every cycle.

module tb_dm_arbiter;
    localparam int DEPTH = 4096;
    localparam int LIM   = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req0_In, We0_In, Req1_In, We1_In;
    logic [31:0] Addr0_In, WData0_In, Pc0_In, Addr1_In, WData1_In, Pc1_In;
    logic        Ack0_Out, Err0_Out, Ack1_Out, Err1_Out;
    logic [31:0] RData0_Out, RData1_Out;
    logic        Mem_Write_Out, Busy_Out;
    logic [31:0] Mem_Addr_Out, Mem_Data_Out, Mem_Pc_Out;
    logic [31:0] Mem_Data_In = '0;

    dm_arbiter #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0_In(Req0_In), .We0_In(We0_In), .Addr0_In(Addr0_In), .WData0_In(WData0_In), .Pc0_In(Pc0_In),
        .Ack0_Out(Ack0_Out), .Err0_Out(Err0_Out), .RData0_Out(RData0_Out),
        .Req1_In(Req1_In), .We1_In(We1_In), .Addr1_In(Addr1_In), .WData1_In(WData1_In), .Pc1_In(Pc1_In),
        .Ack1_Out(Ack1_Out), .Err1_Out(Err1_Out), .RData1_Out(RData1_Out),
        .Mem_Write_Out(Mem_Write_Out), .Mem_Addr_Out(Mem_Addr_Out), .Mem_Data_Out(Mem_Data_Out),
        .Mem_Pc_Out(Mem_Pc_Out), .Mem_Data_In(Mem_Data_In), .Busy_Out(Busy_Out)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } rq_t;

    rq_t  q0[$], q1[$];
    int   alog[$], atime[$];
    logic gaps = 1'b0, rst_noise = 1'b0, mon_en = 1'b0;
    int   n_cmp = 0, n_bad = 0, n_err1 = 0, n_mw = 0, ncyc = 0;

    task automatic ck(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    // ---------------- data memory environment ----------------
    logic [31:0] dm [int];
    logic [31:0] mm [int];

    function automatic logic [31:0] dflt(input logic [31:0] i);
        return 32'h5A00_0000 ^ (i * 32'h0001_9E37);
    endfunction
    function automatic logic [31:0] dm_rd(input logic [31:0] i);
        return dm.exists(int'(i)) ? dm[int'(i)] : dflt(i);
    endfunction
    function automatic logic [31:0] mm_rd(input logic [31:0] i);
        return mm.exists(int'(i)) ? mm[int'(i)] : dflt(i);
    endfunction

    initial begin
        forever begin
            @(posedge Clk); #2;
            Mem_Data_In = dm_rd(Mem_Addr_Out);
            @(negedge Clk);
            if (Mem_Write_Out) dm[int'(Mem_Addr_Out)] = Mem_Data_Out;
        end
    end

    // ---------------- requesters ----------------
    initial begin
        logic a;
        rq_t  r;
        {Req0_In, We0_In, Addr0_In, WData0_In, Pc0_In} = '0;
        forever begin
            @(negedge Clk); a = Ack0_Out;
            @(posedge Clk); #1;
            if (rst_noise) begin
                {Req0_In, We0_In} = 2'($urandom);
                Addr0_In = $urandom; WData0_In = $urandom; Pc0_In = $urandom;
            end else begin
                if (a || !Reset) Req0_In = 1'b0;
                if (!Req0_In && Reset && q0.size() > 0 && (!gaps || $urandom_range(2) != 0)) begin
                    r = q0.pop_front();
                    Req0_In = 1'b1; We0_In = r.we; Addr0_In = r.addr; WData0_In = r.wdata; Pc0_In = r.pc;
                end
            end
        end
    end

    initial begin
        logic a;
        rq_t  r;
        {Req1_In, We1_In, Addr1_In, WData1_In, Pc1_In} = '0;
        forever begin
            @(negedge Clk); a = Ack1_Out;
            @(posedge Clk); #1;
            if (rst_noise) begin
                {Req1_In, We1_In} = 2'($urandom);
                Addr1_In = $urandom; WData1_In = $urandom; Pc1_In = $urandom;
            end else begin
                if (a || !Reset) Req1_In = 1'b0;
                if (!Req1_In && Reset && q1.size() > 0 && (!gaps || $urandom_range(2) != 0)) begin
                    r = q1.pop_front();
                    Req1_In = 1'b1; We1_In = r.we; Addr1_In = r.addr; WData1_In = r.wdata; Pc1_In = r.pc;
                end
            end
        end
    end

    // ---------------- reference model: grant slots on an edge timeline ----------------
    int          e, free_e, acc_e, resp_e, pend_e, w1;
    logic        resp_p, resp_err, acc_we, pend_we, pend_p;
    logic [31:0] acc_idx, acc_data, acc_pc, pend_idx, pend_data;
    logic [31:0] exp_rd [2];

    initial begin
        logic w, bad;
        rq_t  r;
        {resp_p, resp_err, acc_we, pend_we, pend_p} = '0;
        {acc_idx, acc_data, acc_pc, pend_idx, pend_data} = '0;
        forever begin
            @(posedge Clk or negedge Reset);
            if (!Reset) begin
                e = 0; free_e = 0; acc_e = -1; resp_e = -1; pend_e = -1; w1 = 0;
                exp_rd[0] = '0; exp_rd[1] = '0;
            end else begin
                e++;
                if (pend_e == e) begin
                    if (pend_we) mm[int'(pend_idx)] = pend_data;
                    else exp_rd[pend_p] = mm_rd(pend_idx);
                end
                if (e >= free_e && (Req0_In || Req1_In)) begin
                    if (Req0_In && Req1_In) w = (w1 == LIM);
                    else w = Req1_In;
                    if (w) w1 = 0;
                    else if (Req1_In) w1 = (w1 < LIM) ? w1 + 1 : LIM;
                    r = w ? {We1_In, Addr1_In, WData1_In, Pc1_In} : {We0_In, Addr0_In, WData0_In, Pc0_In};
                    bad = (r.addr % 4 != 0) || (r.addr / 4 >= DEPTH);
                    resp_p = w; resp_err = bad;
                    if (bad) begin
                        resp_e = e; free_e = e + 2;
                    end else begin
                        acc_e = e; resp_e = e + 1; free_e = e + 3;
                        acc_we = r.we; acc_idx = r.addr / 4; acc_data = r.wdata; acc_pc = r.pc;
                        pend_e = e + 1; pend_we = r.we; pend_idx = acc_idx; pend_data = r.wdata; pend_p = w;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle monitor ----------------
    initial begin
        logic in_acc, a0, a1;
        forever begin
            @(negedge Clk);
            ncyc++;
            if (Ack0_Out) begin alog.push_back(0); atime.push_back(ncyc); end
            if (Ack1_Out) begin alog.push_back(1); atime.push_back(ncyc); end
            if (Err1_Out) n_err1++;
            if (Mem_Write_Out) n_mw++;
            if (mon_en) begin
                in_acc = (acc_e == e);
                a0 = (resp_e == e) && !resp_p;
                a1 = (resp_e == e) && resp_p;
                ck("ack0",  32'(Ack0_Out), 32'(a0));
                ck("ack1",  32'(Ack1_Out), 32'(a1));
                ck("err0",  32'(Err0_Out), 32'(a0 && resp_err));
                ck("err1",  32'(Err1_Out), 32'(a1 && resp_err));
                ck("mwr",   32'(Mem_Write_Out), 32'(in_acc && acc_we));
                ck("maddr", Mem_Addr_Out, in_acc ? acc_idx : 32'h0);
                ck("mdata", Mem_Data_Out, in_acc ? acc_data : 32'h0);
                ck("mpc",   Mem_Pc_Out, in_acc ? acc_pc : 32'h0);
                ck("busy",  32'(Busy_Out), 32'(e < free_e - 1));
                ck("rdata0", RData0_Out, exp_rd[0]);
                ck("rdata1", RData1_Out, exp_rd[1]);
            end
        end
    end

    task automatic wait_idle();
        logic done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (q0.size() == 0 && q1.size() == 0 && !Req0_In && !Req1_In && !Busy_Out) begin
                done = 1'b1;
                break;
            end
        end
        ck("idle_timeout", 32'(done), 32'h1);
    endtask

    function automatic rq_t rnd_rq();
        rq_t r;
        int  k = int'($urandom_range(9));
        r.we = 1'($urandom_range(1)); r.wdata = $urandom; r.pc = $urandom;
        if (k == 0)      r.addr = ($urandom_range(DEPTH - 1) << 2) | $urandom_range(3, 1);
        else if (k == 1) r.addr = (DEPTH + $urandom_range(100000)) << 2;
        else             r.addr = $urandom_range(63) << 2;
        return r;
    endfunction

    initial begin
        logic [31:0] pre, rd1;
        int          e1, m0;
        logic        seen;
        int          exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // reset with noisy inputs, then release with all requests low
        Reset = 1'b1; #1;
        Reset = 1'b0; rst_noise = 1'b1; mon_en = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk); rst_noise = 1'b0;
        @(negedge Clk); @(negedge Clk); Reset = 1'b1;
        repeat (4) @(negedge Clk);

        // port 0 write then read back
        q0.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'hDEAD_BEEF, pc: 32'h3000});
        wait_idle();
        ck("t2_dm_word4", dm_rd(32'd4), 32'hDEAD_BEEF);
        q0.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, pc: 32'h3004});
        wait_idle();
        ck("t2_rdata0", RData0_Out, 32'hDEAD_BEEF);

        // port 1 error grants: misaligned and out of range
        rd1 = RData1_Out; e1 = n_err1; m0 = n_mw;
        q1.push_back('{we: 1'b1, addr: 32'h6,    wdata: 32'h1111_1111, pc: 32'h40});
        q1.push_back('{we: 1'b1, addr: 32'h4000, wdata: 32'h2222_2222, pc: 32'h44});
        wait_idle();
        ck("t3_err_count", 32'(n_err1 - e1), 32'd2);
        ck("t3_no_mwrite", 32'(n_mw - m0), 32'd0);
        ck("t3_rdata1", RData1_Out, rd1);

        // continuous conflict: starvation guard every fifth grant
        alog.delete(); atime.delete();
        for (int i = 0; i < 8; i++)
            q0.push_back('{we: 1'(i % 2), addr: 32'(i * 4 + 64), wdata: $urandom, pc: 32'(i)});
        for (int i = 0; i < 2; i++)
            q1.push_back('{we: 1'b0, addr: 32'(i * 4), wdata: $urandom, pc: 32'(100 + i)});
        wait_idle();
        ck("t4_grants", 32'(alog.size()), 32'd10);
        for (int i = 0; i < 10 && i < alog.size(); i++)
            ck($sformatf("t4_order%0d", i), 32'(alog[i]), 32'(exp_order[i]));

        // reset in the middle of a write access
        pre = dm_rd(32'd8); seen = 1'b0;
        q0.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'h1234_5678, pc: 32'h50});
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #2;
            if (Mem_Write_Out) begin seen = 1'b1; break; end
        end
        ck("t5_access_seen", 32'(seen), 32'h1);
        Reset = 1'b0; #1;
        ck("t5_mwr_now",  32'(Mem_Write_Out), 32'h0);
        ck("t5_busy_now", 32'(Busy_Out), 32'h0);
        ck("t5_maddr_now", Mem_Addr_Out, 32'h0);
        @(negedge Clk); @(negedge Clk); Reset = 1'b1;
        alog.delete();
        repeat (4) @(negedge Clk);
        ck("t5_no_ack", 32'(alog.size()), 32'h0);
        ck("t5_dm_kept", dm_rd(32'd8), pre);

        // port 1 back-to-back reads
        alog.delete(); atime.delete();
        q1.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0, pc: 32'h60});
        q1.push_back('{we: 1'b0, addr: 32'h4, wdata: 32'h0, pc: 32'h64});
        wait_idle();
        ck("t6_acks", 32'(atime.size()), 32'd2);
        if (atime.size() == 2) ck("t6_spacing", 32'(atime[1] - atime[0]), 32'd3);
        ck("t6_rdata1", RData1_Out, dm_rd(32'd1));

        // random traffic from both ports
        gaps = 1'b1;
        for (int i = 0; i < 80; i++) begin
            q0.push_back(rnd_rq());
            q1.push_back(rnd_rq());
        end
        wait_idle();
        repeat (3) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
